// File: rtl/ether_udp_demo_rx_pkg.sv
// ----------------------------------------------------------------------------
// ether_udp_demo_rx_pkg : shared constants, states and CRC helper for UDP RX
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ether_udp_demo_rx_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PRE       = 3'd2,
    ST_HDR       = 3'd3,
    ST_PAYLOAD   = 3'd4,
    ST_CHECK     = 3'd5,
    ST_DROP      = 3'd6
  } rx_state_t;

  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hd5;

  // Byte offsets counted from the first destination MAC byte (index 0)
  localparam cnt_t OFF_ETH_TYPE   = 12'd12;
  localparam cnt_t OFF_VER_IHL    = 12'd14;
  localparam cnt_t OFF_PROTO      = 12'd23;
  localparam cnt_t OFF_SRC_IP_LSB = 12'd29;
  localparam cnt_t OFF_DST_IP     = 12'd30;
  localparam cnt_t OFF_DST_PORT   = 12'd36;
  localparam cnt_t OFF_HDR_LAST   = 12'd41;
  localparam cnt_t OFF_PAYLOAD    = 12'd42;
  localparam cnt_t MIN_FRAME      = 12'd64;

  localparam logic [31:0] CRC_INIT     = 32'hffff_ffff;
  localparam logic [31:0] CRC_POLY_REF = 32'hedb8_8320;

  // Reflected CRC-32 update, LSB of each byte first as on the wire
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ether_crc32_chk.sv
// ----------------------------------------------------------------------------
// ether_crc32_chk : byte-wide Ethernet CRC-32 accumulator, output in wire order
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ether_crc32_chk
  import ether_udp_demo_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        calc,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_reg <= CRC_INIT;
    end else if (clear) begin
      crc_reg <= CRC_INIT;
    end else if (calc) begin
      crc_reg <= crc32_byte(crc_reg, data);
    end
  end

  // Byte-swapped complement: crc_out[31:24] is the first FCS byte on the wire
  assign crc_out = ~{crc_reg[7:0], crc_reg[15:8], crc_reg[23:16], crc_reg[31:24]};

endmodule

`default_nettype wire

// File: rtl/ether_udp_demo_rx.sv
// ----------------------------------------------------------------------------
// ether_udp_demo_rx : GMII UDP demo receiver with MAC/IP/port filter and FCS
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ether_udp_demo_rx
  import ether_udp_demo_rx_pkg::*;
#(
  parameter logic [47:0] BASE_MAC_ADDR = 48'h00301ba0a470,
  parameter logic [31:0] BASE_IP_ADDR  = {8'd172, 8'd16, 8'd0, 8'd100},
  parameter logic [15:0] UDP_PORT      = 16'd8888,
  parameter logic [11:0] MAX_FRAME     = 12'd1518
) (
  input  logic        phy_rx_clk,
  input  logic        rst_n,
  input  logic        phy_rx_dv,
  input  logic        phy_rx_er,
  input  logic [7:0]  phy_rx_data,
  input  logic        id,
  output logic [6:0]  data_out,
  output logic        data_valid,
  output logic        peer_id,
  output logic [15:0] good_cnt,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] drop_cnt
);

  rx_state_t   state;
  cnt_t        cnt;
  logic [31:0] fcs_dly;
  logic [6:0]  data_tmp;
  logic        peer_id_tmp;
  logic        bcast_ok;
  logic        ucast_ok;

  logic [47:0] own_mac;
  logic [31:0] own_ip;
  logic [7:0]  exp_byte;
  logic        is_mac;
  logic        must_match;
  logic        bcast_next;
  logic        ucast_next;
  logic        hdr_ok;
  logic        too_long;
  logic        crc_clear;
  logic        crc_calc;
  logic [31:0] crc_out;

  assign own_mac = {BASE_MAC_ADDR[47:1], id};
  assign own_ip  = {BASE_IP_ADDR[31:1], id};

  always_comb begin
    exp_byte   = 8'h00;
    is_mac     = 1'b0;
    must_match = 1'b0;
    case (cnt)
      12'd0:                  begin is_mac = 1'b1; exp_byte = own_mac[47:40]; end
      12'd1:                  begin is_mac = 1'b1; exp_byte = own_mac[39:32]; end
      12'd2:                  begin is_mac = 1'b1; exp_byte = own_mac[31:24]; end
      12'd3:                  begin is_mac = 1'b1; exp_byte = own_mac[23:16]; end
      12'd4:                  begin is_mac = 1'b1; exp_byte = own_mac[15:8];  end
      12'd5:                  begin is_mac = 1'b1; exp_byte = own_mac[7:0];   end
      OFF_ETH_TYPE:           begin must_match = 1'b1; exp_byte = ETH_TYPE_IPV4[15:8]; end
      OFF_ETH_TYPE + 12'd1:   begin must_match = 1'b1; exp_byte = ETH_TYPE_IPV4[7:0];  end
      OFF_VER_IHL:            begin must_match = 1'b1; exp_byte = IP_VER_IHL;          end
      OFF_PROTO:              begin must_match = 1'b1; exp_byte = IP_PROTO_UDP;        end
      OFF_DST_IP:             begin must_match = 1'b1; exp_byte = own_ip[31:24];       end
      OFF_DST_IP + 12'd1:     begin must_match = 1'b1; exp_byte = own_ip[23:16];       end
      OFF_DST_IP + 12'd2:     begin must_match = 1'b1; exp_byte = own_ip[15:8];        end
      OFF_DST_IP + 12'd3:     begin must_match = 1'b1; exp_byte = own_ip[7:0];         end
      OFF_DST_PORT:           begin must_match = 1'b1; exp_byte = UDP_PORT[15:8];      end
      OFF_DST_PORT + 12'd1:   begin must_match = 1'b1; exp_byte = UDP_PORT[7:0];       end
      default:                begin end
    endcase
  end

  // Broadcast and unicast MAC matches are tracked in parallel across bytes 0-5
  assign bcast_next = bcast_ok & (phy_rx_data == 8'hff);
  assign ucast_next = ucast_ok & (phy_rx_data == exp_byte);
  assign hdr_ok     = is_mac ? (bcast_next | ucast_next)
                             : (!must_match || (phy_rx_data == exp_byte));
  assign too_long   = (cnt == MAX_FRAME);

  assign crc_clear = (state == ST_PRE) && phy_rx_dv && (phy_rx_data == SFD);
  assign crc_calc  = ((state == ST_HDR) || (state == ST_PAYLOAD)) && phy_rx_dv && (cnt >= 12'd4);

  ether_crc32_chk u_crc (
    .clk     (phy_rx_clk),
    .rst_n   (rst_n),
    .clear   (crc_clear),
    .calc    (crc_calc),
    .data    (fcs_dly[31:24]),
    .crc_out (crc_out)
  );

  always_ff @(posedge phy_rx_clk) begin
    if (!rst_n) begin
      state       <= ST_WAIT_IDLE;
      cnt         <= '0;
      fcs_dly     <= '0;
      data_tmp    <= '0;
      peer_id_tmp <= 1'b0;
      bcast_ok    <= 1'b0;
      ucast_ok    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      peer_id     <= 1'b0;
      good_cnt    <= '0;
      crc_err_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_WAIT_IDLE: begin
          if (!phy_rx_dv) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (phy_rx_dv && (phy_rx_data == PREAMBLE)) state <= ST_PRE;
        end
        ST_PRE: begin
          if (phy_rx_dv && (phy_rx_data == SFD)) begin
            state    <= ST_HDR;
            cnt      <= '0;
            bcast_ok <= 1'b1;
            ucast_ok <= 1'b1;
          end else if (!(phy_rx_dv && (phy_rx_data == PREAMBLE))) begin
            state <= ST_WAIT_IDLE;
          end
        end
        ST_HDR: begin
          if (!phy_rx_dv) begin
            drop_cnt <= drop_cnt + 16'd1;
            state    <= ST_IDLE;
          end else if (phy_rx_er || !hdr_ok || too_long) begin
            drop_cnt <= drop_cnt + 16'd1;
            state    <= ST_DROP;
          end else begin
            cnt     <= cnt + 12'd1;
            fcs_dly <= {fcs_dly[23:0], phy_rx_data};
            if (is_mac) begin
              bcast_ok <= bcast_next;
              ucast_ok <= ucast_next;
            end
            if (cnt == OFF_SRC_IP_LSB) peer_id_tmp <= phy_rx_data[0];
            if (cnt == OFF_HDR_LAST) state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!phy_rx_dv) begin
            state <= ST_CHECK;
          end else if (phy_rx_er || too_long) begin
            drop_cnt <= drop_cnt + 16'd1;
            state    <= ST_DROP;
          end else begin
            cnt     <= cnt + 12'd1;
            fcs_dly <= {fcs_dly[23:0], phy_rx_data};
            if (cnt == OFF_PAYLOAD) data_tmp <= phy_rx_data[6:0];
          end
        end
        ST_CHECK: begin
          // The delay line now holds exactly the four FCS bytes
          if (cnt < MIN_FRAME) begin
            drop_cnt <= drop_cnt + 16'd1;
          end else if (crc_out == fcs_dly) begin
            data_out   <= data_tmp;
            peer_id    <= peer_id_tmp;
            data_valid <= 1'b1;
            good_cnt   <= good_cnt + 16'd1;
          end else begin
            crc_err_cnt <= crc_err_cnt + 16'd1;
          end
          state <= ST_IDLE;
        end
        ST_DROP: begin
          if (!phy_rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ether_udp_demo_rx.sv
// ----------------------------------------------------------------------------
// tb_ether_udp_demo_rx : directed frame bench for ether_udp_demo_rx
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ether_udp_demo_rx;

  localparam logic [47:0] MAC_ID0   = 48'h00301ba0a470;
  localparam logic [47:0] MAC_ID1   = 48'h00301ba0a471;
  localparam logic [47:0] MAC_BCAST = 48'hffffffffffff;
  localparam logic [31:0] IP_ID0    = 32'hac100064;  // 172.16.0.100
  localparam logic [31:0] IP_ID1    = 32'hac100065;  // 172.16.0.101

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv    = 1'b0;
  logic        er    = 1'b0;
  logic [7:0]  rxd   = 8'h00;
  logic        id    = 1'b0;
  logic [6:0]  data_out;
  logic        data_valid;
  logic        peer_id;
  logic [15:0] good_cnt;
  logic [15:0] crc_err_cnt;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int p0;
  logic [7:0] frm[$];

  ether_udp_demo_rx dut (
    .phy_rx_clk  (clk),
    .rst_n       (rst_n),
    .phy_rx_dv   (dv),
    .phy_rx_er   (er),
    .phy_rx_data (rxd),
    .id          (id),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .peer_id     (peer_id),
    .good_cnt    (good_cnt),
    .crc_err_cnt (crc_err_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #4 clk = ~clk;

  always @(negedge clk) if (data_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [47:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) frm.push_back(v[8*k +: 8]);
  endtask

  // Standard Ethernet FCS, least significant byte transmitted first
  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hffffffff;
    foreach (frm[k]) begin
      c = c ^ {24'd0, frm[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic build(input logic [47:0] dmac, input logic [47:0] smac,
                       input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] dport, input logic [6:0] d7, input int plen);
    frm.delete();
    push(dmac, 6);
    push(smac, 6);
    push(48'h0800, 2);
    push(48'h4500, 2);
    push(48'(28 + plen), 2);
    push(48'h0000, 2);
    push(48'h4000, 2);
    push(48'h4011, 2);
    push(48'h0000, 2);
    push({16'd0, sip}, 4);
    push({16'd0, dip}, 4);
    push(48'd1234, 2);
    push({32'd0, dport}, 2);
    push(48'(8 + plen), 2);
    push(48'h0000, 2);
    frm.push_back({1'b1, d7});
    for (int k = 1; k < plen; k++) frm.push_back(8'hdd);
    append_fcs();
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    dv  = 1'b1;
    rxd = b;
  endtask

  task automatic send_frame(input int er_at, input int cut_at, input int rst_at);
    int n;
    n = (cut_at >= 0) ? cut_at : frm.size();
    repeat (7) drive(8'h55);
    drive(8'hd5);
    for (int i = 0; i < n; i++) begin
      drive(frm[i]);
      er = (i == er_at);
      if (i == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && i == rst_at + 3) rst_n = 1'b1;
    end
    @(negedge clk);
    dv    = 1'b0;
    er    = 1'b0;
    rxd   = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    settle();

    // Reset state
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_peer_id", 32'(peer_id), 32'h0);
    check("rst_good", 32'(good_cnt), 32'h0);
    check("rst_crc_err", 32'(crc_err_cnt), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);

    // Loopback TX id 0 -> RX id 1, minimum 64-byte frame, exact latency
    id = 1'b1;
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h5a, 18);
    p0 = pulses;
    send_frame(-1, -1, -1);
    @(negedge clk);
    check("lat_n1_valid", 32'(data_valid), 32'h0);
    @(negedge clk);
    check("lat_n2_valid", 32'(data_valid), 32'h1);
    check("t1_data_out", 32'(data_out), 32'h5a);
    check("t1_peer_id", 32'(peer_id), 32'h0);
    @(negedge clk);
    check("t1_pulse_width", 32'(data_valid), 32'h0);
    settle();
    check("t1_good", 32'(good_cnt), 32'h1);
    check("t1_crc_err", 32'(crc_err_cnt), 32'h0);
    check("t1_drop", 32'(drop_cnt), 32'h0);
    check("t1_pulses", 32'(pulses - p0), 32'h1);

    // Corrupted payload byte dd -> dc
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h33, 18);
    frm[43] = 8'hdc;
    p0 = pulses;
    send_frame(-1, -1, -1);
    settle();
    check("t2_crc_err", 32'(crc_err_cnt), 32'h1);
    check("t2_good", 32'(good_cnt), 32'h1);
    check("t2_data_hold", 32'(data_out), 32'h5a);
    check("t2_pulses", 32'(pulses - p0), 32'h0);

    // Broadcast MAC from peer id 1 to RX id 0
    id = 1'b0;
    build(MAC_BCAST, MAC_ID1, IP_ID1, IP_ID0, 16'd8888, 7'h11, 18);
    send_frame(-1, -1, -1);
    settle();
    check("t2b_good", 32'(good_cnt), 32'h2);
    check("t2b_data_out", 32'(data_out), 32'h11);
    check("t2b_peer_id", 32'(peer_id), 32'h1);

    // Filter rejections: dest IP, UDP port, dest MAC
    do_reset();
    id = 1'b0;
    build(MAC_ID0, MAC_ID1, IP_ID1, IP_ID1, 16'd8888, 7'h01, 18);
    send_frame(-1, -1, -1);
    settle();
    check("t3_ip_drop", 32'(drop_cnt), 32'h1);
    id = 1'b1;
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8887, 7'h02, 18);
    send_frame(-1, -1, -1);
    settle();
    check("t3_port_drop", 32'(drop_cnt), 32'h2);
    check("t3_port_good", 32'(good_cnt), 32'h0);
    build(MAC_ID0, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h03, 18);
    send_frame(-1, -1, -1);
    settle();
    check("t3_mac_drop", 32'(drop_cnt), 32'h3);
    check("t3_crc_err", 32'(crc_err_cnt), 32'h0);

    // rx_er mid-header, then two clean frames each after one idle cycle
    do_reset();
    id = 1'b1;
    p0 = pulses;
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h44, 18);
    send_frame(20, -1, -1);
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    settle();
    check("t4_drop", 32'(drop_cnt), 32'h1);
    check("t4_good", 32'(good_cnt), 32'h2);
    check("t4_pulses", 32'(pulses - p0), 32'h2);
    check("t4_data_out", 32'(data_out), 32'h44);

    // Runts and aborted preamble
    do_reset();
    id = 1'b1;
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h55, 17);
    send_frame(-1, -1, -1);
    settle();
    check("t5_len63_drop", 32'(drop_cnt), 32'h1);
    check("t5_len63_good", 32'(good_cnt), 32'h0);
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h55, 18);
    send_frame(-1, 50, -1);
    settle();
    check("t5_cut50_drop", 32'(drop_cnt), 32'h2);
    check("t5_cut50_crc_err", 32'(crc_err_cnt), 32'h0);
    drive(8'h55);
    drive(8'h55);
    @(negedge clk);
    dv = 1'b0;
    settle();
    check("t5_pre_drop", 32'(drop_cnt), 32'h2);
    check("t5_pre_good", 32'(good_cnt), 32'h0);
    check("t5_pre_crc_err", 32'(crc_err_cnt), 32'h0);
    send_frame(-1, 10, -1);
    settle();
    check("t5_hdr_cut_drop", 32'(drop_cnt), 32'h3);

    // Reset mid-frame, then a normal frame
    do_reset();
    id = 1'b1;
    p0 = pulses;
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h66, 18);
    send_frame(-1, -1, 30);
    settle();
    check("t6_good", 32'(good_cnt), 32'h0);
    check("t6_crc_err", 32'(crc_err_cnt), 32'h0);
    check("t6_drop", 32'(drop_cnt), 32'h0);
    check("t6_pulses", 32'(pulses - p0), 32'h0);
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h2a, 18);
    send_frame(-1, -1, -1);
    settle();
    check("t6_next_good", 32'(good_cnt), 32'h1);
    check("t6_next_data", 32'(data_out), 32'h2a);

    // Length limit: 1519 bytes rejected, 1518 accepted
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h70, 1473);
    send_frame(-1, -1, -1);
    settle();
    check("t7_long_drop", 32'(drop_cnt), 32'h1);
    check("t7_long_good", 32'(good_cnt), 32'h1);
    build(MAC_ID1, MAC_ID0, IP_ID0, IP_ID1, 16'd8888, 7'h71, 1472);
    send_frame(-1, -1, -1);
    settle();
    check("t7_max_good", 32'(good_cnt), 32'h2);
    check("t7_max_data", 32'(data_out), 32'h71);
    check("t7_crc_err", 32'(crc_err_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
